// File: rtl/decode_pkg.sv
// Shared decode constants: RV32I opcodes, one-hot class indices, ALU codes,
// immediate formats and the registered decode-slot payload.
package decode_pkg;

    localparam int unsigned OPC_W = 7;
    localparam int unsigned CLS_W = 11;
    localparam int unsigned ALU_W = 4;
    localparam int unsigned REG_W = 5;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned IMM_W = 32;

    // Major opcodes (instr[6:0])
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_FENCE  = 7'b0001111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

    // Bit positions in the one-hot class vector
    localparam int unsigned CLS_LUI    = 0;
    localparam int unsigned CLS_AUIPC  = 1;
    localparam int unsigned CLS_JAL    = 2;
    localparam int unsigned CLS_JALR   = 3;
    localparam int unsigned CLS_BRANCH = 4;
    localparam int unsigned CLS_LOAD   = 5;
    localparam int unsigned CLS_STORE  = 6;
    localparam int unsigned CLS_OPIMM  = 7;
    localparam int unsigned CLS_OP     = 8;
    localparam int unsigned CLS_FENCE  = 9;
    localparam int unsigned CLS_SYSTEM = 10;

    // ALU operation codes
    localparam logic [ALU_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_W-1:0] ALU_SLL  = 4'd2;
    localparam logic [ALU_W-1:0] ALU_SLT  = 4'd3;
    localparam logic [ALU_W-1:0] ALU_SLTU = 4'd4;
    localparam logic [ALU_W-1:0] ALU_XOR  = 4'd5;
    localparam logic [ALU_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALU_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'd8;
    localparam logic [ALU_W-1:0] ALU_AND  = 4'd9;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    // Decoded fields carried in the pipeline slot (PC is kept separately)
    typedef struct packed {
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic [F3_W-1:0]  funct3;
        logic [IMM_W-1:0] imm;
        logic [CLS_W-1:0] opcode;
        logic [ALU_W-1:0] alu;
        logic             illegal;
        logic             ecall;
        logic             ebreak;
    } decode_slot_t;

    // One-hot class vector with only bit idx set
    function automatic logic [CLS_W-1:0] onehot(input int unsigned idx);
        return CLS_W'(1) << idx;
    endfunction

    // Classes that read rs1 / rs2
    localparam logic [CLS_W-1:0] RS1_USERS = onehot(CLS_JALR)  | onehot(CLS_BRANCH) |
                                             onehot(CLS_LOAD)  | onehot(CLS_STORE)  |
                                             onehot(CLS_OPIMM) | onehot(CLS_OP)     |
                                             onehot(CLS_SYSTEM);
    localparam logic [CLS_W-1:0] RS2_USERS = onehot(CLS_BRANCH) | onehot(CLS_STORE) |
                                             onehot(CLS_OP);

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extraction; all formats sign-extend from instr[31].
module imm_gen
    import decode_pkg::*;
(
    input  logic [31:0]      instr,
    input  imm_fmt_e         fmt,
    output logic [IMM_W-1:0] imm
);

    // Select and assemble the immediate for the requested format
    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/instruction_decode.sv
// RV32I decode stage: one registered slot, load-use bubble insertion and
// stall/flush forwarding. Optional feature macro: DECODE_ILLEGAL_EN enables
// the illegal/ecall/ebreak flags; otherwise they are tied to 0.
module instruction_decode
    import decode_pkg::*;
#(
    parameter int unsigned IWIDTH   = 32,
    parameter int unsigned PC_WIDTH = 32
) (
    input  logic                d_clk,
    input  logic                d_rst,
    input  logic [IWIDTH-1:0]   d_i_instr,
    input  logic [PC_WIDTH-1:0] d_i_pc,
    input  logic                d_i_ce,
    input  logic                d_i_stall,
    input  logic                d_i_flush,
    output logic                d_o_ce,
    output logic                d_o_stall,
    output logic                d_o_flush,
    output logic [PC_WIDTH-1:0] d_o_pc,
    output logic [REG_W-1:0]    d_o_addr_rs1,
    output logic [REG_W-1:0]    d_o_addr_rs2,
    output logic [REG_W-1:0]    d_o_addr_rd,
    output logic [F3_W-1:0]     d_o_funct3,
    output logic [IMM_W-1:0]    d_o_imm,
    output logic [CLS_W-1:0]    d_o_opcode,
    output logic [ALU_W-1:0]    d_o_alu,
    output logic                d_o_illegal,
    output logic                d_o_ecall,
    output logic                d_o_ebreak
);

    logic [31:0]      instr;
    logic [OPC_W-1:0] opc;
    logic [F3_W-1:0]  f3;
    logic [6:0]       f7;
    logic [CLS_W-1:0] cls;
    imm_fmt_e         fmt;
    logic [IMM_W-1:0] imm;
    logic [ALU_W-1:0] alu;
    logic             illegal;
    logic             ecall;
    logic             ebreak;
    decode_slot_t     dec;

    decode_slot_t     slot_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic             ce_q;
    logic             flush_q;

    logic             uses_rs1;
    logic             uses_rs2;
    logic             rs1_hit;
    logic             rs2_hit;
    logic             hz;

    assign instr = d_i_instr[31:0];
    assign opc   = instr[6:0];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];

    // Opcode to one-hot class and immediate format
    always_comb begin
        cls = '0;
        fmt = IMM_NONE;
        case (opc)
            OPC_LUI:    begin cls = onehot(CLS_LUI);    fmt = IMM_U; end
            OPC_AUIPC:  begin cls = onehot(CLS_AUIPC);  fmt = IMM_U; end
            OPC_JAL:    begin cls = onehot(CLS_JAL);    fmt = IMM_J; end
            OPC_JALR:   begin cls = onehot(CLS_JALR);   fmt = IMM_I; end
            OPC_BRANCH: begin cls = onehot(CLS_BRANCH); fmt = IMM_B; end
            OPC_LOAD:   begin cls = onehot(CLS_LOAD);   fmt = IMM_I; end
            OPC_STORE:  begin cls = onehot(CLS_STORE);  fmt = IMM_S; end
            OPC_OPIMM:  begin cls = onehot(CLS_OPIMM);  fmt = IMM_I; end
            OPC_OP:     begin cls = onehot(CLS_OP);     fmt = IMM_NONE; end
            OPC_FENCE:  begin cls = onehot(CLS_FENCE);  fmt = IMM_NONE; end
            OPC_SYSTEM: begin cls = onehot(CLS_SYSTEM); fmt = IMM_I; end
            default:    begin cls = '0;                 fmt = IMM_NONE; end
        endcase
    end

    imm_gen u_imm_gen (
        .instr (instr),
        .fmt   (fmt),
        .imm   (imm)
    );

    // ALU operation: funct3/instr[30] for OP and OPIMM, SUB for branches, else ADD
    always_comb begin
        alu = ALU_ADD;
        if ((opc == OPC_OP) || (opc == OPC_OPIMM)) begin
            case (f3)
                3'd0:    alu = ((opc == OPC_OP) && instr[30]) ? ALU_SUB : ALU_ADD;
                3'd1:    alu = ALU_SLL;
                3'd2:    alu = ALU_SLT;
                3'd3:    alu = ALU_SLTU;
                3'd4:    alu = ALU_XOR;
                3'd5:    alu = instr[30] ? ALU_SRA : ALU_SRL;
                3'd6:    alu = ALU_OR;
                default: alu = ALU_AND;
            endcase
        end else if (opc == OPC_BRANCH) begin
            alu = ALU_SUB;
        end
    end

`ifdef DECODE_ILLEGAL_EN
    // Exception flags: unknown opcode, bad funct7 encodings, ecall/ebreak words
    always_comb begin
        illegal = (cls == '0);
        if (opc == OPC_OP) begin
            if (!((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))))) begin
                illegal = 1'b1;
            end
        end else if (opc == OPC_OPIMM) begin
            if ((f3 == 3'd1) && (f7 != 7'h00)) begin
                illegal = 1'b1;
            end
            if ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20)) begin
                illegal = 1'b1;
            end
        end
        ecall  = (instr == 32'h0000_0073);
        ebreak = (instr == 32'h0010_0073);
    end
`else
    assign illegal = 1'b0;
    assign ecall   = 1'b0;
    assign ebreak  = 1'b0;
`endif

    // Assemble the next slot contents from the presented instruction
    always_comb begin
        dec         = '0;
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.rd      = instr[11:7];
        dec.funct3  = f3;
        dec.imm     = imm;
        dec.opcode  = cls;
        dec.alu     = alu;
        dec.illegal = illegal;
        dec.ecall   = ecall;
        dec.ebreak  = ebreak;
    end

    // Load-use hazard: held LOAD writes a register the presented instruction reads
    assign uses_rs1  = |(cls & RS1_USERS);
    assign uses_rs2  = |(cls & RS2_USERS);
    assign rs1_hit   = uses_rs1 && (instr[19:15] == slot_q.rd);
    assign rs2_hit   = uses_rs2 && (instr[24:20] == slot_q.rd);
    assign hz        = ce_q && slot_q.opcode[CLS_LOAD] && (slot_q.rd != '0) &&
                       d_i_ce && (rs1_hit || rs2_hit);
    assign d_o_stall = d_i_stall | hz;

    // Pipeline slot: flush > stall > hazard bubble > load
    always_ff @(posedge d_clk or negedge d_rst) begin
        if (!d_rst) begin
            slot_q  <= '0;
            pc_q    <= '0;
            ce_q    <= 1'b0;
            flush_q <= 1'b0;
        end else if (d_i_flush) begin
            ce_q    <= 1'b0;
            flush_q <= 1'b1;
        end else begin
            flush_q <= 1'b0;
            if (!d_i_stall) begin
                if (hz) begin
                    ce_q <= 1'b0;
                end else begin
                    slot_q <= dec;
                    pc_q   <= d_i_pc;
                    ce_q   <= d_i_ce;
                end
            end
        end
    end

    assign d_o_ce       = ce_q;
    assign d_o_flush    = flush_q;
    assign d_o_pc       = pc_q;
    assign d_o_addr_rs1 = slot_q.rs1;
    assign d_o_addr_rs2 = slot_q.rs2;
    assign d_o_addr_rd  = slot_q.rd;
    assign d_o_funct3   = slot_q.funct3;
    assign d_o_imm      = slot_q.imm;
    assign d_o_opcode   = slot_q.opcode;
    assign d_o_alu      = slot_q.alu;
    assign d_o_illegal  = slot_q.illegal;
    assign d_o_ecall    = slot_q.ecall;
    assign d_o_ebreak   = slot_q.ebreak;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: decode table plus hazard, stall,
// flush and mid-stream reset sequences. Honors DECODE_ILLEGAL_EN.
module tb_instruction_decode;

`ifdef DECODE_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic        d_clk = 1'b0;
    logic        d_rst = 1'b0;
    logic [31:0] d_i_instr = '0;
    logic [31:0] d_i_pc = '0;
    logic        d_i_ce = 1'b0;
    logic        d_i_stall = 1'b0;
    logic        d_i_flush = 1'b0;
    logic        d_o_ce;
    logic        d_o_stall;
    logic        d_o_flush;
    logic [31:0] d_o_pc;
    logic [4:0]  d_o_addr_rs1;
    logic [4:0]  d_o_addr_rs2;
    logic [4:0]  d_o_addr_rd;
    logic [2:0]  d_o_funct3;
    logic [31:0] d_o_imm;
    logic [10:0] d_o_opcode;
    logic [3:0]  d_o_alu;
    logic        d_o_illegal;
    logic        d_o_ecall;
    logic        d_o_ebreak;

    instruction_decode #(.IWIDTH(32), .PC_WIDTH(32)) dut (
        .d_clk        (d_clk),
        .d_rst        (d_rst),
        .d_i_instr    (d_i_instr),
        .d_i_pc       (d_i_pc),
        .d_i_ce       (d_i_ce),
        .d_i_stall    (d_i_stall),
        .d_i_flush    (d_i_flush),
        .d_o_ce       (d_o_ce),
        .d_o_stall    (d_o_stall),
        .d_o_flush    (d_o_flush),
        .d_o_pc       (d_o_pc),
        .d_o_addr_rs1 (d_o_addr_rs1),
        .d_o_addr_rs2 (d_o_addr_rs2),
        .d_o_addr_rd  (d_o_addr_rd),
        .d_o_funct3   (d_o_funct3),
        .d_o_imm      (d_o_imm),
        .d_o_opcode   (d_o_opcode),
        .d_o_alu      (d_o_alu),
        .d_o_illegal  (d_o_illegal),
        .d_o_ecall    (d_o_ecall),
        .d_o_ebreak   (d_o_ebreak)
    );

    always #5 d_clk = ~d_clk;

    typedef struct {
        logic [31:0] instr;
        logic [10:0] cls;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        ill;
        logic        ecall;
        logic        ebreak;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge d_clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic ce, input logic st, input logic fl);
        d_i_instr = ins;
        d_i_pc    = pc;
        d_i_ce    = ce;
        d_i_stall = st;
        d_i_flush = fl;
    endtask

    function automatic vec_t mk(input logic [31:0] ins, input logic [10:0] cls,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [2:0] f3,
                                input logic [31:0] imm, input logic [3:0] alu,
                                input logic ill, input logic ec, input logic eb);
        vec_t v;
        v.instr = ins; v.cls = cls; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.f3 = f3; v.imm = imm; v.alu = alu; v.ill = ill; v.ecall = ec; v.ebreak = eb;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                instr          class    rs1 rs2 rd  f3  imm            alu ill ec eb
        vecs[0]  = mk(32'h00510093, 11'h080, 2,  5,  1,  0, 32'h00000005, 0, 0, 0, 0); // addi x1,x2,5
        vecs[1]  = mk(32'hFE208CE3, 11'h010, 1,  2,  25, 0, 32'hFFFFFFF8, 1, 0, 0, 0); // beq -8
        vecs[2]  = mk(32'h123452B7, 11'h001, 8,  3,  5,  5, 32'h12345000, 0, 0, 0, 0); // lui
        vecs[3]  = mk(32'h80000317, 11'h002, 0,  0,  6,  0, 32'h80000000, 0, 0, 0, 0); // auipc
        vecs[4]  = mk(32'hFFDFF0EF, 11'h004, 31, 29, 1,  7, 32'hFFFFFFFC, 0, 0, 0, 0); // jal -4
        vecs[5]  = mk(32'h00C08067, 11'h008, 1,  12, 0,  0, 32'h0000000C, 0, 0, 0, 0); // jalr 12(x1)
        vecs[6]  = mk(32'hFE512E23, 11'h040, 2,  5,  28, 2, 32'hFFFFFFFC, 0, 0, 0, 0); // sw -4(x2)
        vecs[7]  = mk(32'h405201B3, 11'h100, 4,  5,  3,  0, 32'h00000000, 1, 0, 0, 0); // sub
        vecs[8]  = mk(32'h40345393, 11'h080, 8,  3,  7,  5, 32'h00000403, 7, 0, 0, 0); // srai
        vecs[9]  = mk(32'h00B534B3, 11'h100, 10, 11, 9,  3, 32'h00000000, 4, 0, 0, 0); // sltu
        vecs[10] = mk(32'h0FF0000F, 11'h200, 0,  31, 0,  0, 32'h00000000, 0, 0, 0, 0); // fence
        vecs[11] = mk(32'h00000073, 11'h400, 0,  0,  0,  0, 32'h00000000, 0, 0, 1, 0); // ecall
        vecs[12] = mk(32'h00100073, 11'h400, 0,  1,  0,  0, 32'h00000001, 0, 0, 0, 1); // ebreak
        vecs[13] = mk(32'hFFFFFFFF, 11'h000, 31, 31, 31, 7, 32'h00000000, 0, 1, 0, 0); // unknown
        vecs[14] = mk(32'h40005033, 11'h100, 0,  0,  0,  5, 32'h00000000, 7, 0, 0, 0); // sra
        vecs[15] = mk(32'h02004033, 11'h100, 0,  0,  0,  4, 32'h00000000, 5, 1, 0, 0); // OP f7=0x01
        vecs[16] = mk(32'h40004033, 11'h100, 0,  0,  0,  4, 32'h00000000, 5, 1, 0, 0); // OP f7=0x20,f3=4
        vecs[17] = mk(32'h40001013, 11'h080, 0,  0,  0,  1, 32'h00000400, 2, 1, 0, 0); // slli f7=0x20

        // Reset state; stall passes straight through during reset
        d_i_stall = 1'b1;
        #2;
        chk("rst_stall_passthru", 32'(d_o_stall), 32'd1);
        chk("rst_ce", 32'(d_o_ce), 32'd0);
        chk("rst_flush", 32'(d_o_flush), 32'd0);
        chk("rst_pc", d_o_pc, 32'd0);
        chk("rst_imm", d_o_imm, 32'd0);
        chk("rst_opcode", 32'(d_o_opcode), 32'd0);
        chk("rst_flags", {29'd0, d_o_illegal, d_o_ecall, d_o_ebreak}, 32'd0);
        d_i_stall = 1'b0;
        #1;
        chk("rst_stall_low", 32'(d_o_stall), 32'd0);
        tick();
        tick();
        d_rst = 1'b1;

        // Decode table
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].instr, 32'h100 + 32'(i) * 4, 1'b1, 1'b0, 1'b0);
            #1;
            chk($sformatf("v%0d_stall", i), 32'(d_o_stall), 32'd0);
            tick();
            chk($sformatf("v%0d_ce", i), 32'(d_o_ce), 32'd1);
            chk($sformatf("v%0d_pc", i), d_o_pc, 32'h100 + 32'(i) * 4);
            chk($sformatf("v%0d_class", i), 32'(d_o_opcode), 32'(vecs[i].cls));
            chk($sformatf("v%0d_rs1", i), 32'(d_o_addr_rs1), 32'(vecs[i].rs1));
            chk($sformatf("v%0d_rs2", i), 32'(d_o_addr_rs2), 32'(vecs[i].rs2));
            chk($sformatf("v%0d_rd", i), 32'(d_o_addr_rd), 32'(vecs[i].rd));
            chk($sformatf("v%0d_funct3", i), 32'(d_o_funct3), 32'(vecs[i].f3));
            chk($sformatf("v%0d_imm", i), d_o_imm, vecs[i].imm);
            chk($sformatf("v%0d_alu", i), 32'(d_o_alu), 32'(vecs[i].alu));
            chk($sformatf("v%0d_illegal", i), 32'(d_o_illegal), 32'(vecs[i].ill & ILL_EN));
            chk($sformatf("v%0d_ecall", i), 32'(d_o_ecall), 32'(vecs[i].ecall & ILL_EN));
            chk($sformatf("v%0d_ebreak", i), 32'(d_o_ebreak), 32'(vecs[i].ebreak & ILL_EN));
            chk($sformatf("v%0d_flush", i), 32'(d_o_flush), 32'd0);
        end

        // Invalid presentation: slot loads but stays invalid
        drive(32'h00510093, 32'h1F0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("ce0_slot_invalid", 32'(d_o_ce), 32'd0);

        // Load-use hazard: one stall cycle, one bubble, then the consumer
        drive(32'h0000A183, 32'h200, 1'b1, 1'b0, 1'b0);   // lw x3,0(x1)
        tick();
        chk("lw_ce", 32'(d_o_ce), 32'd1);
        chk("lw_class", 32'(d_o_opcode), 32'h020);
        chk("lw_rd", 32'(d_o_addr_rd), 32'd3);
        drive(32'h00518233, 32'h204, 1'b1, 1'b0, 1'b0);   // add x4,x3,x5
        #1;
        chk("hz_stall", 32'(d_o_stall), 32'd1);
        tick();
        chk("hz_bubble_ce", 32'(d_o_ce), 32'd0);
        chk("hz_cleared", 32'(d_o_stall), 32'd0);
        tick();
        chk("hz_add_ce", 32'(d_o_ce), 32'd1);
        chk("hz_add_pc", d_o_pc, 32'h204);
        chk("hz_add_rs1", 32'(d_o_addr_rs1), 32'd3);
        chk("hz_add_rs2", 32'(d_o_addr_rs2), 32'd5);
        chk("hz_add_rd", 32'(d_o_addr_rd), 32'd4);

        // Load to x0 never stalls
        drive(32'h0000A003, 32'h208, 1'b1, 1'b0, 1'b0);   // lw x0,0(x1)
        tick();
        drive(32'h00500233, 32'h20C, 1'b1, 1'b0, 1'b0);   // add x4,x0,x5
        #1;
        chk("x0_no_stall", 32'(d_o_stall), 32'd0);
        tick();
        chk("x0_add_ce", 32'(d_o_ce), 32'd1);
        chk("x0_add_pc", d_o_pc, 32'h20C);

        // Downstream stall holds the slot for 3 cycles
        drive(32'h00510093, 32'h210, 1'b1, 1'b1, 1'b0);
        #1;
        chk("stall_out", 32'(d_o_stall), 32'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stall%0d_ce", c), 32'(d_o_ce), 32'd1);
            chk($sformatf("stall%0d_pc", c), d_o_pc, 32'h20C);
            chk($sformatf("stall%0d_rd", c), 32'(d_o_addr_rd), 32'd4);
            chk($sformatf("stall%0d_stall", c), 32'(d_o_stall), 32'd1);
        end
        d_i_stall = 1'b0;
        tick();
        chk("unstall_pc", d_o_pc, 32'h210);
        chk("unstall_imm", d_o_imm, 32'd5);

        // Stall and hazard together: stall wins, hazard re-evaluated after
        drive(32'h0000A183, 32'h214, 1'b1, 1'b0, 1'b0);
        tick();
        drive(32'h00518233, 32'h218, 1'b1, 1'b1, 1'b0);
        tick();
        chk("sthz_hold_ce", 32'(d_o_ce), 32'd1);
        chk("sthz_hold_pc", d_o_pc, 32'h214);
        d_i_stall = 1'b0;
        #1;
        chk("sthz_hz_after", 32'(d_o_stall), 32'd1);
        tick();
        chk("sthz_bubble", 32'(d_o_ce), 32'd0);
        tick();
        chk("sthz_add_ce", 32'(d_o_ce), 32'd1);
        chk("sthz_add_pc", d_o_pc, 32'h218);

        // Flush and hazard together: flush wins, no bubble afterwards
        drive(32'h0000A183, 32'h21C, 1'b1, 1'b0, 1'b0);
        tick();
        drive(32'h00518233, 32'h220, 1'b1, 1'b0, 1'b1);
        tick();
        chk("flush_ce", 32'(d_o_ce), 32'd0);
        chk("flush_flag", 32'(d_o_flush), 32'd1);
        d_i_flush = 1'b0;
        #1;
        chk("flush_no_hz", 32'(d_o_stall), 32'd0);
        tick();
        chk("flush_clear", 32'(d_o_flush), 32'd0);
        chk("flush_next_ce", 32'(d_o_ce), 32'd1);
        chk("flush_next_pc", d_o_pc, 32'h220);

        // Mid-stream reset clears outputs without waiting for a clock edge
        #2;
        d_rst = 1'b0;
        #1;
        chk("mrst_ce", 32'(d_o_ce), 32'd0);
        chk("mrst_pc", d_o_pc, 32'd0);
        chk("mrst_opcode", 32'(d_o_opcode), 32'd0);
        chk("mrst_rd", 32'(d_o_addr_rd), 32'd0);
        chk("mrst_rs1", 32'(d_o_addr_rs1), 32'd0);
        chk("mrst_alu", 32'(d_o_alu), 32'd0);
        tick();
        d_rst = 1'b1;
        drive(32'h00510093, 32'h300, 1'b1, 1'b0, 1'b0);
        tick();
        chk("post_rst_ce", 32'(d_o_ce), 32'd1);
        chk("post_rst_pc", d_o_pc, 32'h300);
        chk("post_rst_imm", d_o_imm, 32'd5);
        chk("post_rst_class", 32'(d_o_opcode), 32'h080);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_decode.md
# instruction_decode

Second pipeline stage of the core. It consumes the fetched instruction word and its PC from `instruction_fetch`, decodes RV32I fields into one registered pipeline slot, and forwards ce/stall/flush along the pipeline. It detects load-use hazards against the instruction it currently holds and inserts exactly one bubble when one occurs. It sits between `instruction_fetch` and the execute/ALU stage.

## Interface
- `IWIDTH`, 32, instruction width.
- `PC_WIDTH`, 32, PC width.
- `d_clk`  in  1  clock.
- `d_rst`  in  1  asynchronous, active-low reset.
- `d_i_instr`  in  IWIDTH  instruction word, driven by fetch `f_o_instr`.
- `d_i_pc`  in  PC_WIDTH  PC of the instruction, driven by fetch `f_o_addr_instr`.
- `d_i_ce`  in  1  a valid instruction is presented.
- `d_i_stall`  in  1  downstream stall.
- `d_i_flush`  in  1  downstream flush (taken branch/jump).
- `d_o_ce`  out  1  the decoded slot is valid.
- `d_o_stall`  out  1  combinational stall request to fetch.
- `d_o_flush`  out  1  registered flush indication.
- `d_o_pc`  out  PC_WIDTH  PC of the decoded instruction.
- `d_o_addr_rs1`, `d_o_addr_rs2`, `d_o_addr_rd`  out  5 each  register addresses.
- `d_o_funct3`  out  3  funct3 field.
- `d_o_imm`  out  32  sign-extended immediate.
- `d_o_opcode`  out  11  one-hot opcode class.
- `d_o_alu`  out  4  ALU operation code.
- `d_o_illegal`, `d_o_ecall`, `d_o_ebreak`  out  1 each  exception flags.

## Operation
- Opcode classes, by one-hot bit index: LUI(0) 0110111, AUIPC(1) 0010111, JAL(2) 1101111, JALR(3) 1100111, BRANCH(4) 1100011, LOAD(5) 0000011, STORE(6) 0100011, OPIMM(7) 0010011, OP(8) 0110011, FENCE(9) 0001111, SYSTEM(10) 1110011. An unknown opcode produces an all-zero class vector.
- Immediate formats:
  - I: JALR, LOAD, OPIMM, SYSTEM.
  - S: STORE.
  - B: BRANCH, bit 0 = 0.
  - U: LUI, AUIPC, low 12 bits = 0.
  - J: JAL.
  - All immediates are sign-extended from instr[31]. OP and FENCE produce imm = 0.
- ALU codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9.
  - OP/OPIMM: derived from funct3 and instr[30]. SUB applies to OP only. SRA applies to OP and OPIMM.
  - BRANCH: SUB.
  - All other classes: ADD.
- Register usage:
  - rs1 is used by all classes except LUI, AUIPC, JAL and FENCE.
  - rs2 is used by BRANCH, STORE and OP.
  - The address outputs carry raw fields regardless of usage.
- Load-use hazard (`hz`) is asserted when all of the following hold: `d_o_ce`=1, the slot class is LOAD, `d_o_addr_rd`≠0, `d_i_ce`=1, and the presented instruction uses rs1 or rs2 equal to `d_o_addr_rd`.
- `d_o_stall` = `d_i_stall` | `hz`. Fetch holds `d_i_instr`, `d_i_pc` and `d_i_ce` stable while `d_o_stall`=1.
- Per-edge priority, highest first:
  1. `d_i_flush`: `d_o_ce`←0 and `d_o_flush`←1. All other outputs are don't-care.
  2. `d_i_stall`: all outputs hold their values, including `d_o_ce`. `d_o_flush`←0.
  3. `hz`: `d_o_ce`←0, which inserts a bubble. Fields hold. The slot is no longer a valid LOAD, so `hz` clears and the held instruction is accepted on the next edge.
  4. Otherwise: the slot loads the decode of the presented instruction and `d_o_ce`←`d_i_ce`.
- When no flush occurs, `d_o_flush`←0.

## Timing
- Decode latency is 1 cycle: the instruction presented at edge N appears at the outputs after edge N.
- Reset values: every output register is 0, including `d_o_ce`, `d_o_flush`, `d_o_pc`, `d_o_imm`, `d_o_opcode` and all flags. `d_o_stall` therefore evaluates to `d_i_stall` during reset.
- A hazard costs exactly one bubble cycle.
- Flush and hazard in the same cycle: flush wins and no bubble follows.
- Stall and hazard in the same cycle: stall wins, and `hz` is re-evaluated after the stall releases.
- When reset is asserted mid-operation, all output registers clear immediately. There is no pending state.

## Configuration
- `DECODE_ILLEGAL_EN` defined:
  - `d_o_illegal`=1 for an unknown opcode.
  - `d_o_illegal`=1 for an OP instruction with funct7 ∉ {0x00, 0x20}, or with 0x20 on funct3 other than 0 or 5.
  - `d_o_illegal`=1 for an OPIMM shift with an invalid funct7.
  - `d_o_ecall`=1 for 0x00000073. `d_o_ebreak`=1 for 0x00100073.
  - Flags are registered with the slot and are valid only when `d_o_ce`=1.
- `DECODE_ILLEGAL_EN` undefined: all three flags are tied to 0, and an illegal instruction passes through with its raw decode.

## Structure
- Package `decode_pkg` holds:
  - the opcode constants;
  - the one-hot bit index constants;
  - the ALU code constants;
  - the immediate-format enum.
- Sub-module `imm_gen` is combinational: instr and format in, 32-bit immediate out.
- The top level contains the classification logic, the hazard compare and the pipeline register.

## Test plan
- Reset then `addi x1,x2,5` (0x00510093), `d_i_pc`=0x10, `d_i_ce`=1 → after one edge: `d_o_ce`=1, OPIMM bit 7 set, rs1=2, rd=1, imm=5, alu=ADD, pc=0x10.
- `beq x1,x2,-8` (0xFE208CE3) → class bit 4, imm=0xFFFFFFF8, alu=SUB, rs1=1, rs2=2.
- `lw x3,0(x1)` (0x0000A183) followed by `add x4,x3,x5` (0x00518233) → `d_o_stall`=1 for one cycle, then `d_o_ce`=0 for one cycle, then the add appears with rs1=3 and rs2=5. Repeat with rd=x0: no stall.
- `d_i_stall`=1 for 3 cycles with a valid slot → outputs are unchanged and `d_o_stall`=1. Assert `d_i_flush` together with a hazard → next `d_o_ce`=0, `d_o_flush`=1, then `d_o_flush`=0.
- With `DECODE_ILLEGAL_EN` defined: 0xFFFFFFFF → `d_o_illegal`=1; 0x00000073 → `d_o_ecall`=1; 0x40005033 (`sra x0,x0,x0`, funct7 0x20) → illegal=0, alu=SRA. Without the macro: every flag is 0.
- Assert reset mid-stream with `d_o_ce`=1 → all outputs go to 0 immediately, and decode resumes cleanly after reset is released.
